// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter between the CPU and DMA.
package mem_arbiter_pkg;

  // Strobe levels on the active-low CPU/RAM bus.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Width of the starvation counter; STARVE_MAX must fit in it.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_FORCE = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_e;

  // Saturating increment so a long CPU burst can never wrap the counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_port_mux.sv
// Selects which requester's address, data and strobes reach the RAM port.
module arb_port_mux
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              sel_dma_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_d_in_i,
  input  logic              cpu_rd_n_i,
  input  logic              cpu_wr_n_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  input  logic              dma_we_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_d_in_o,
  output logic              ram_rd_n_o,
  output logic              ram_wr_n_o
);

  // The DMA side turns its single we bit into the pair of active-low strobes.
  assign ram_addr_o = sel_dma_i ? dma_addr_i  : cpu_addr_i;
  assign ram_d_in_o = sel_dma_i ? dma_wdata_i : cpu_d_in_i;
  assign ram_rd_n_o = sel_dma_i ? (dma_we_i ? DISABLE_ : ENABLE_) : cpu_rd_n_i;
  assign ram_wr_n_o = sel_dma_i ? (dma_we_i ? ENABLE_ : DISABLE_) : cpu_wr_n_i;

endmodule

// File: rtl/mem_arbiter.sv
// Data-RAM arbiter: CPU has priority, DMA steals idle slots or forces a
// one-cycle CPU hold after waiting STARVE_MAX cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | no DMA transfer in progress, CPU owns RAM
// ARB_WAIT  | DMA pending, waiting for an idle CPU slot, counting busy cycles
// ARB_FORCE | DMA starved: CPU held for this cycle, DMA owns RAM
// ARB_ACK   | access done, ack held until the requester drops dma_req
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_d_in,
  input  logic              cpu_rd_,
  input  logic              cpu_wr_,
  output logic [DATA_W-1:0] cpu_d_out,
  output logic              cpu_hold_,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d_in,
  input  logic [DATA_W-1:0] ram_d_out,
  output logic              ram_rd_,
  output logic              ram_wr_
);

  localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              sel_dma;
  logic              cpu_idle;
  logic              mux_rd_n, mux_wr_n;

  assign cpu_idle = (cpu_rd_ == DISABLE_) && (cpu_wr_ == DISABLE_);

  // State, starvation counter and captured read data.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state, port select and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    sel_dma = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (dma_req) begin
          state_d = ARB_WAIT;
          cnt_d   = '0;
        end
      end
      ARB_WAIT: begin
        if (!dma_req) begin
          state_d = ARB_IDLE;
        end else if (cpu_idle) begin
          sel_dma = 1'b1;
          if (!dma_we) rdata_d = ram_d_out;
          state_d = ARB_ACK;
        end else begin
          cnt_d = sat_inc(cnt_q);
          if (cnt_q == STARVE_LAST) state_d = ARB_FORCE;
        end
      end
      ARB_FORCE: begin
        sel_dma = 1'b1;
        if (!dma_we) rdata_d = ram_d_out;
        state_d = ARB_ACK;
      end
      ARB_ACK: begin
        if (!dma_req) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  arb_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .sel_dma_i   (sel_dma),
    .cpu_addr_i  (cpu_addr),
    .cpu_d_in_i  (cpu_d_in),
    .cpu_rd_n_i  (cpu_rd_),
    .cpu_wr_n_i  (cpu_wr_),
    .dma_addr_i  (dma_addr),
    .dma_wdata_i (dma_wdata),
    .dma_we_i    (dma_we),
    .ram_addr_o  (ram_addr),
    .ram_d_in_o  (ram_d_in),
    .ram_rd_n_o  (mux_rd_n),
    .ram_wr_n_o  (mux_wr_n)
  );

  // Strobes are forced inactive while reset is asserted so nothing lands in RAM.
  assign ram_rd_ = rst_ ? mux_rd_n : DISABLE_;
  assign ram_wr_ = rst_ ? mux_wr_n : DISABLE_;

  assign cpu_d_out = ram_d_out;
  assign cpu_hold_ = (state_q == ARB_FORCE) ? ENABLE_ : DISABLE_;
  assign dma_ack   = (state_q == ARB_ACK);
  assign dma_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with an asynchronous-read RAM model.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_d_in = '0, cpu_d_out;
  logic       cpu_rd_ = 1'b1, cpu_wr_ = 1'b1, cpu_hold_;
  logic       dma_req = 1'b0, dma_we = 1'b0, dma_ack;
  logic [7:0] dma_addr = '0, dma_wdata = '0, dma_rdata;
  logic [7:0] ram_addr, ram_d_in, ram_d_out;
  logic       ram_rd_, ram_wr_;

  logic [7:0] mem [256];
  int         wr_count = 0;
  int         hold_cnt = 0;
  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] sb_q [$];

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .cpu_addr  (cpu_addr),
    .cpu_d_in  (cpu_d_in),
    .cpu_rd_   (cpu_rd_),
    .cpu_wr_   (cpu_wr_),
    .cpu_d_out (cpu_d_out),
    .cpu_hold_ (cpu_hold_),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .ram_addr  (ram_addr),
    .ram_d_in  (ram_d_in),
    .ram_d_out (ram_d_out),
    .ram_rd_   (ram_rd_),
    .ram_wr_   (ram_wr_)
  );

  always #5 clk = ~clk;

  // RAM model: asynchronous read, write on the rising edge; also counts
  // writes and held CPU cycles.
  assign ram_d_out = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_wr_ == 1'b0) begin
      mem[ram_addr] <= ram_d_in;
      wr_count      <= wr_count + 1;
    end
    if (cpu_hold_ == 1'b0) hold_cnt <= hold_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_d_in = d;
    cpu_wr_  = 1'b0;
    cpu_rd_  = 1'b1;
    step();
    cpu_wr_  = 1'b1;
  endtask

  task automatic wait_ack(input int max_cyc, output int cyc);
    cyc = 0;
    while (dma_ack !== 1'b1 && cyc < max_cyc) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_addr  = 8'($urandom);
      cpu_d_in  = 8'($urandom);
      cpu_rd_   = 1'($urandom);
      cpu_wr_   = 1'($urandom);
      dma_req   = 1'($urandom);
      dma_we    = 1'($urandom);
      dma_addr  = 8'($urandom);
      dma_wdata = 8'($urandom);
      #3;
      vec_cnt++;
      if (cpu_hold_ !== 1'b1) begin err_cnt++; $display("FAIL reset_hold: got %b want 1", cpu_hold_); end
      vec_cnt++;
      if (dma_ack !== 1'b0) begin err_cnt++; $display("FAIL reset_ack: got %b want 0", dma_ack); end
      vec_cnt++;
      if (dma_rdata !== 8'h00) begin err_cnt++; $display("FAIL reset_rdata: got %h want 00", dma_rdata); end
      vec_cnt++;
      if (ram_addr !== cpu_addr) begin err_cnt++; $display("FAIL reset_addr: got %h want %h", ram_addr, cpu_addr); end
      vec_cnt++;
      if (ram_d_in !== cpu_d_in) begin err_cnt++; $display("FAIL reset_din: got %h want %h", ram_d_in, cpu_d_in); end
      vec_cnt++;
      if (ram_rd_ !== 1'b1 || ram_wr_ !== 1'b1) begin
        err_cnt++; $display("FAIL reset_strobes: got rd=%b wr=%b want 1/1", ram_rd_, ram_wr_);
      end
      @(posedge clk);
    end
    #1;
    dma_req = 1'b0;
    cpu_rd_ = 1'b1;
    cpu_wr_ = 1'b1;
    step();
    rst_ = 1'b1;
    step();
  endtask

  task automatic test_idle_read();
    int c;
    int h0;
    cpu_write(8'h20, 8'h5A);
    h0 = hold_cnt;
    dma_req  = 1'b1;
    dma_we   = 1'b0;
    dma_addr = 8'h20;
    sb_q.push_back(8'h5A);
    step();
    vec_cnt++;
    if (ram_addr !== 8'h20 || ram_rd_ !== 1'b0 || ram_wr_ !== 1'b1) begin
      err_cnt++; $display("FAIL idle_slot_ram: got addr=%h rd=%b wr=%b want 20/0/1", ram_addr, ram_rd_, ram_wr_);
    end
    wait_ack(8, c);
    vec_cnt++;
    if (dma_ack !== 1'b1 || c + 1 != 2) begin
      err_cnt++; $display("FAIL idle_latency: got ack=%b cycles=%0d want 1/2", dma_ack, c + 1);
    end
    vec_cnt++;
    if (dma_rdata !== sb_q[0]) begin err_cnt++; $display("FAIL idle_rdata: got %h want %h", dma_rdata, sb_q[0]); end
    void'(sb_q.pop_front());
    vec_cnt++;
    if (hold_cnt != h0) begin err_cnt++; $display("FAIL idle_no_hold: got %0d held cycles want 0", hold_cnt - h0); end
    dma_req = 1'b0;
    step();
    vec_cnt++;
    if (dma_ack !== 1'b0) begin err_cnt++; $display("FAIL idle_ack_drop: got %b want 0", dma_ack); end
  endtask

  task automatic test_starvation();
    int n;
    int h0;
    int w0;
    cpu_write(8'h40, 8'h00);
    h0 = hold_cnt;
    w0 = wr_count;
    cpu_addr  = 8'h11;
    cpu_rd_   = 1'b0;
    dma_req   = 1'b1;
    dma_we    = 1'b1;
    dma_addr  = 8'h40;
    dma_wdata = 8'h33;
    sb_q.push_back(8'h5A);
    n = 0;
    while (cpu_hold_ !== 1'b0 && n < 12) begin
      step();
      n++;
      if (n == 3) begin
        vec_cnt++;
        if (ram_addr !== 8'h11 || ram_rd_ !== 1'b0 || ram_wr_ !== 1'b1) begin
          err_cnt++; $display("FAIL starve_wait_cpu: got addr=%h rd=%b wr=%b want 11/0/1", ram_addr, ram_rd_, ram_wr_);
        end
      end
    end
    vec_cnt++;
    if (cpu_hold_ !== 1'b0 || n != 5) begin
      err_cnt++; $display("FAIL starve_hold_time: got hold=%b at cycle %0d want 0 at 5", cpu_hold_, n);
    end
    vec_cnt++;
    if (ram_addr !== 8'h40 || ram_wr_ !== 1'b0 || ram_rd_ !== 1'b1 || ram_d_in !== 8'h33) begin
      err_cnt++; $display("FAIL starve_force_ram: got addr=%h wr=%b rd=%b din=%h want 40/0/1/33",
                          ram_addr, ram_wr_, ram_rd_, ram_d_in);
    end
    step();
    vec_cnt++;
    if (dma_ack !== 1'b1 || cpu_hold_ !== 1'b1) begin
      err_cnt++; $display("FAIL starve_ack: got ack=%b hold=%b want 1/1", dma_ack, cpu_hold_);
    end
    vec_cnt++;
    if (mem[8'h40] !== 8'h33) begin err_cnt++; $display("FAIL starve_ram_data: got %h want 33", mem[8'h40]); end
    vec_cnt++;
    if (hold_cnt - h0 != 1) begin err_cnt++; $display("FAIL starve_hold_len: got %0d want 1", hold_cnt - h0); end
    vec_cnt++;
    if (wr_count - w0 != 1) begin err_cnt++; $display("FAIL starve_writes: got %0d want 1", wr_count - w0); end
    vec_cnt++;
    if (dma_rdata !== sb_q[0]) begin err_cnt++; $display("FAIL starve_rdata_kept: got %h want %h", dma_rdata, sb_q[0]); end
    void'(sb_q.pop_front());
    dma_req = 1'b0;
    cpu_rd_ = 1'b1;
    step();
  endtask

  task automatic test_abort();
    int w0;
    int c;
    cpu_write(8'h50, 8'h00);
    w0 = wr_count;
    cpu_addr  = 8'h12;
    cpu_rd_   = 1'b0;
    dma_req   = 1'b1;
    dma_we    = 1'b1;
    dma_addr  = 8'h50;
    dma_wdata = 8'h77;
    step();
    dma_req = 1'b0;
    #1;
    vec_cnt++;
    if (ram_addr !== 8'h12 || ram_wr_ !== 1'b1) begin
      err_cnt++; $display("FAIL abort_ram: got addr=%h wr=%b want 12/1", ram_addr, ram_wr_);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vec_cnt++;
      if (dma_ack !== 1'b0) begin err_cnt++; $display("FAIL abort_no_ack: got %b want 0", dma_ack); end
    end
    vec_cnt++;
    if (wr_count != w0 || mem[8'h50] !== 8'h00) begin
      err_cnt++; $display("FAIL abort_no_write: got %0d writes mem=%h want 0/00", wr_count - w0, mem[8'h50]);
    end
    cpu_rd_ = 1'b1;
    dma_req = 1'b1;
    dma_we  = 1'b0;
    sb_q.push_back(8'h00);
    wait_ack(8, c);
    vec_cnt++;
    if (dma_ack !== 1'b1 || c != 2) begin
      err_cnt++; $display("FAIL abort_back_to_idle: got ack=%b cycles=%0d want 1/2", dma_ack, c);
    end
    vec_cnt++;
    if (dma_rdata !== sb_q[0]) begin err_cnt++; $display("FAIL abort_reread: got %h want %h", dma_rdata, sb_q[0]); end
    void'(sb_q.pop_front());
    dma_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int c;
    int w0;
    cpu_write(8'h60, 8'hA5);
    dma_req  = 1'b1;
    dma_we   = 1'b0;
    dma_addr = 8'h60;
    sb_q.push_back(8'hA5);
    wait_ack(8, c);
    vec_cnt++;
    if (dma_ack !== 1'b1 || c != 2) begin
      err_cnt++; $display("FAIL hs_first_ack: got ack=%b cycles=%0d want 1/2", dma_ack, c);
    end
    vec_cnt++;
    if (dma_rdata !== sb_q[0]) begin err_cnt++; $display("FAIL hs_rdata: got %h want %h", dma_rdata, sb_q[0]); end
    w0 = wr_count;
    cpu_addr = 8'h99;
    for (int i = 0; i < 5; i++) begin
      step();
      vec_cnt++;
      if (dma_ack !== 1'b1 || ram_addr !== 8'h99 || ram_rd_ !== 1'b1 || dma_rdata !== sb_q[0]) begin
        err_cnt++; $display("FAIL hs_hold: got ack=%b addr=%h rd=%b rdata=%h want 1/99/1/%h",
                            dma_ack, ram_addr, ram_rd_, dma_rdata, sb_q[0]);
      end
    end
    void'(sb_q.pop_front());
    vec_cnt++;
    if (wr_count != w0) begin err_cnt++; $display("FAIL hs_no_second: got %0d writes want 0", wr_count - w0); end
    dma_req = 1'b0;
    step();
    vec_cnt++;
    if (dma_ack !== 1'b0) begin err_cnt++; $display("FAIL hs_drop: got %b want 0", dma_ack); end
    dma_req   = 1'b1;
    dma_we    = 1'b1;
    dma_addr  = 8'h61;
    dma_wdata = 8'hC3;
    sb_q.push_back(8'hA5);
    wait_ack(8, c);
    vec_cnt++;
    if (dma_ack !== 1'b1 || c != 2 || mem[8'h61] !== 8'hC3) begin
      err_cnt++; $display("FAIL hs_fresh_write: got ack=%b cycles=%0d mem=%h want 1/2/c3", dma_ack, c, mem[8'h61]);
    end
    vec_cnt++;
    if (dma_rdata !== sb_q[0]) begin err_cnt++; $display("FAIL hs_write_keeps_rdata: got %h want %h", dma_rdata, sb_q[0]); end
    void'(sb_q.pop_front());
    dma_req = 1'b0;
    step();
  endtask

  task automatic test_force_reset();
    int n;
    int w0;
    cpu_write(8'h70, 8'h00);
    w0 = wr_count;
    cpu_addr  = 8'h13;
    cpu_rd_   = 1'b0;
    dma_req   = 1'b1;
    dma_we    = 1'b1;
    dma_addr  = 8'h70;
    dma_wdata = 8'hEE;
    n = 0;
    while (cpu_hold_ !== 1'b0 && n < 12) begin
      step();
      n++;
    end
    vec_cnt++;
    if (cpu_hold_ !== 1'b0) begin err_cnt++; $display("FAIL frst_reach_force: got hold=%b want 0", cpu_hold_); end
    #2;
    rst_ = 1'b0;
    #1;
    vec_cnt++;
    if (cpu_hold_ !== 1'b1 || dma_ack !== 1'b0 || ram_wr_ !== 1'b1) begin
      err_cnt++; $display("FAIL frst_async: got hold=%b ack=%b wr=%b want 1/0/1", cpu_hold_, dma_ack, ram_wr_);
    end
    vec_cnt++;
    if (dma_rdata !== 8'h00) begin err_cnt++; $display("FAIL frst_rdata: got %h want 00", dma_rdata); end
    dma_req = 1'b0;
    cpu_rd_ = 1'b1;
    step();
    step();
    rst_ = 1'b1;
    step();
    step();
    vec_cnt++;
    if (wr_count != w0 || mem[8'h70] !== 8'h00) begin
      err_cnt++; $display("FAIL frst_no_write: got %0d writes mem=%h want 0/00", wr_count - w0, mem[8'h70]);
    end
    vec_cnt++;
    if (cpu_hold_ !== 1'b1 || dma_ack !== 1'b0) begin
      err_cnt++; $display("FAIL frst_after: got hold=%b ack=%b want 1/0", cpu_hold_, dma_ack);
    end
  endtask

  initial begin
    test_reset();
    test_idle_read();
    test_starvation();
    test_abort();
    test_back_to_back();
    test_force_reset();
    vec_cnt++;
    if (sb_q.size() != 0) begin err_cnt++; $display("FAIL sb_drain: got %0d entries want 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single data-RAM port between the miniCPU core and a DMA/debug requester. The CPU keeps priority: DMA accesses use cycles where the CPU issues no RAM strobe. If the DMA has waited too long, the arbiter stalls the CPU for one cycle through a hold line. The block sits between `minicpu` and the RAM model; the CPU's `ram_*` outputs go to the `cpu_*` ports here.

## Interface
- `ADDR_W`, default 8: address width; equals `` `AddrBus`` width.
- `DATA_W`, default 8: data width; equals `` `DataBus`` width.
- `STARVE_MAX`, default 4: number of consecutive WAIT cycles without an idle CPU slot before the CPU is forced to hold; legal range 1–15.
- `clk` in 1: single clock; all state is on the rising edge.
- `rst_` in 1: asynchronous, active-low reset.
- `cpu_addr` in ADDR_W: CPU RAM address.
- `cpu_d_in` in DATA_W: CPU write data.
- `cpu_rd_` in 1: CPU read strobe, active-low.
- `cpu_wr_` in 1: CPU write strobe, active-low.
- `cpu_d_out` out DATA_W: RAM read data to the CPU; equals `ram_d_out` combinationally.
- `cpu_hold_` out 1: active-low stall. While low, the CPU PC and regfile do not update.
- `dma_req` in 1: DMA request, level.
- `dma_we` in 1: 1 = write, 0 = read.
- `dma_addr` in ADDR_W: DMA address.
- `dma_wdata` in DATA_W: DMA write data.
- `dma_ack` out 1: access complete, level.
- `dma_rdata` out DATA_W: registered read data, valid while `dma_ack` = 1.
- `ram_addr` out ADDR_W: address to RAM.
- `ram_d_in` out DATA_W: write data to RAM.
- `ram_d_out` in DATA_W: read data from RAM.
- `ram_rd_` out 1: RAM read strobe, active-low.
- `ram_wr_` out 1: RAM write strobe, active-low.

## Operation
- **FSM states:** IDLE, WAIT, FORCE, ACK. Reset state is IDLE.
- **IDLE:**
  - RAM is driven by the CPU fields directly.
  - `dma_req` = 1 moves the FSM to WAIT and clears the wait counter.
- **WAIT:**
  - If `cpu_rd_` and `cpu_wr_` are both `` `DISABLE_`` this cycle (idle slot), DMA fields drive RAM combinationally. `ram_rd_`/`ram_wr_` follow `dma_we`.
  - On an idle-slot read, `ram_d_out` is captured into `dma_rdata` at the edge. The FSM goes to ACK.
  - Otherwise the CPU drives RAM and the counter increments.
  - When the counter reaches `STARVE_MAX - 1` with the CPU still busy, the FSM goes to FORCE.
- **FORCE:**
  - `cpu_hold_` = 0.
  - DMA drives RAM; CPU strobes are ignored.
  - Read data is captured; the FSM goes to ACK.
- **ACK:**
  - `dma_ack` = 1; RAM is driven by the CPU.
  - The FSM returns to IDLE when `dma_req` = 0 (4-phase handshake).
  - A new request is recognised only from IDLE.
- **Abort:** `dma_req` falling in WAIT returns the FSM to IDLE with no RAM access and no ack.
- **DMA write:** `dma_rdata` keeps its previous value.
- **Both CPU strobes enabled together:** passed through unchanged. This is a CPU bug, not handled here.
- **Counter:** 4 bits; saturates, never wraps.

## Timing
- **Reset values:**
  - `cpu_hold_` = 1, `dma_ack` = 0, `dma_rdata` = 0, counter = 0.
  - `ram_rd_`/`ram_wr_` = `` `DISABLE_``.
- **Reset mid-operation:** asserting reset mid-FORCE releases `cpu_hold_` immediately (asynchronous) and drops `dma_ack`.
- **DMA latency:**
  - Best case, req→ack: 2 cycles (IDLE→WAIT, idle slot→ACK).
  - Worst case: `STARVE_MAX` + 2 cycles.
- **CPU stall:** exactly 1 cycle per forced access. No CPU stall ever occurs via an idle slot.
- **RAM signal paths:** all RAM outputs are combinational from FSM state plus inputs. The RAM is asynchronous-read, matching the CPU's single-cycle datapath.
- **Outputs:** `dma_ack`, `dma_rdata`, and `cpu_hold_` are decoded from registered state only.

## Structure
- **`minicpu.h`:**
  - Add the state encodings `ARB_IDLE`, `ARB_WAIT`, `ARB_FORCE`, `ARB_ACK` (2 bits).
  - Reuse `` `ENABLE_``/`` `DISABLE_``, `` `AddrBus``, `` `DataBus``.
- **Sub-module:** one, `arb_port_mux`: a combinational selector of {addr, d_in, rd_, wr_} between the CPU and DMA, driven by a `sel_dma` signal.
- **CPU integration:** the CPU-side hold gating in `PC`/`regfile` enables belongs to the CPU integration, not to this block.

## Test plan
1. **Reset:** hold `rst_` = 0 with random inputs → `cpu_hold_` = 1, `dma_ack` = 0, `dma_rdata` = 0x00, RAM follows the CPU.
2. **Idle-slot read:** RAM[0x20] = 0x5A; CPU idle; `dma_req` = 1, `dma_we` = 0, `dma_addr` = 0x20 → `dma_ack` rises 2 cycles later with `dma_rdata` = 0x5A; `cpu_hold_` never 0.
3. **Starvation:** CPU strobes `cpu_rd_` = 0 every cycle; DMA write 0x33 to 0x40; `STARVE_MAX` = 4 → `cpu_hold_` = 0 for exactly 1 cycle after 4 WAIT cycles; RAM[0x40] = 0x33; the CPU's read in the held cycle does not reach RAM.
4. **Abort:** `dma_req` pulse of 1 cycle while the CPU is busy → no RAM write, no `dma_ack`, FSM back to IDLE.
5. **Handshake hold:** keep `dma_req` = 1 for 5 cycles after ack → `dma_ack` stays 1 and there is no second access; drop req → ack = 0 next cycle; a new req then starts a fresh access.
6. **Async reset in FORCE:** assert `rst_` = 0 while in FORCE → `cpu_hold_` = 1 with no clock edge; no DMA write lands after release.
